// File: rtl/vram_scanout_arbiter.sv
// Single-port VRAM arbiter: fixed-slot 1bpp scanout fetches plus CPU access on free cycles.
// Optional macro VRAM_ARB_BLANK_WRITE_EN restricts CPU writes to vertical blanking.
module vram_scanout_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hpos,
  input  logic [9:0]        ypos,
  input  logic              display_on,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              pix_out
);

  // state | meaning
  // IDLE  | no CPU access in flight; may issue one on a non-slot cycle
  // DATA  | VRAM returns data for the issued CPU access; ack pulses

  typedef enum logic {IDLE, DATA} state_t;
  state_t state, state_nxt;

  localparam logic [9:0]        H_FETCH_END  = 10'(H_ACTIVE - 8);
  localparam logic [9:0]        H_WRAP_FETCH = 10'(H_TOTAL - 3);
  localparam logic [9:0]        H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]        V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0]        V_ACT_M1     = 10'(V_ACTIVE - 1);
  localparam logic [9:0]        V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] LINE_STRIDE  = ADDR_W'(H_ACTIVE / 8);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);

  logic [ADDR_W-1:0] line_addr, col_addr, video_addr;
  logic [7:0]        hold, shifter;
  logic              fetch_d;
  logic              line_active, next_line_active, wrap_fetch;
  logic              video_slot, write_ok, cpu_issue;

  assign line_active      = (ypos < V_ACT);
  assign next_line_active = (ypos == V_LAST) || (ypos < V_ACT_M1);
  assign wrap_fetch       = (hpos == H_WRAP_FETCH);
  assign video_slot = !reset && (hpos[2:0] == 3'd5) &&
                      (((hpos < H_FETCH_END) && line_active) || (wrap_fetch && next_line_active));

  // The end-of-line fetch precedes the line_addr step at H_TOTAL-1, so it targets the next line base.
  assign video_addr = wrap_fetch ? (line_active ? line_addr + LINE_STRIDE : line_addr)
                                 : line_addr + col_addr;

`ifdef VRAM_ARB_BLANK_WRITE_EN
  assign write_ok = !cpu_we || !line_active;
`else
  assign write_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      line_addr <= '0;
      col_addr  <= '0;
      hold      <= '0;
      shifter   <= '0;
      fetch_d   <= 1'b0;
    end else begin
      fetch_d <= video_slot;
      if (fetch_d) hold <= mem_rdata;
      if (hpos[2:0] == 3'd7) shifter <= hold;
      else                   shifter <= {shifter[6:0], 1'b0};

      if (ypos == V_LAST && hpos == 10'd0)  line_addr <= fb_base;
      else if (hpos == H_LAST && line_active) line_addr <= line_addr + LINE_STRIDE;

      // The wrap fetch itself consumes column 0.
      if (wrap_fetch)      col_addr <= video_slot ? ADDR_ONE : '0;
      else if (video_slot) col_addr <= col_addr + ADDR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_issue = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: if (cpu_req && !video_slot && write_ok && !reset) begin
        cpu_issue = 1'b1;
        state_nxt = DATA;
      end
      DATA: state_nxt = IDLE;
    endcase
    if (video_slot) begin
      mem_en   = 1'b1;
      mem_addr = video_addr;
    end else if (cpu_issue) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign cpu_ack   = (state == DATA) && !reset;
  assign cpu_rdata = cpu_ack ? mem_rdata : 8'h00;
  assign pix_out   = shifter[7] && display_on && !reset;

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Bench for vram_scanout_arbiter: scanout address/pixel model, CPU vector table, corner sequences.
module tb_vram_scanout_arbiter;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    hpos, ypos;
  logic          display_on;
  logic [AW-1:0] fb_base, cpu_addr, mem_addr;
  logic          cpu_req, cpu_we, cpu_ack, mem_en, mem_we, pix_out;
  logic [7:0]    cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;

  logic [7:0] vram [4096];
  logic [7:0] gold [4096];
  logic [7:0] exp_q [$];
  logic       pix_q [$];
  int n_cmp = 0, n_bad = 0;
  bit track = 0, hammer = 0;
  int hammer_acks = 0;

  typedef struct {
    int          h;
    int          y;
    bit          we;
    logic [11:0] addr;
    logic [7:0]  wd;
    int          ack_off;
  } vec_t;
  vec_t vecs [14];

  always #5 clk = ~clk;

  vram_scanout_arbiter dut (
    .clk(clk), .reset(reset), .hpos(hpos), .ypos(ypos), .display_on(display_on),
    .fb_base(fb_base), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_out(pix_out)
  );

  always @(posedge clk) begin
    if (mem_en && mem_we)  vram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= vram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (hpos=%0d ypos=%0d)", nm, act, exp, hpos, ypos);
    end
  endtask

  function automatic bit slot_f(int h, int y);
    return (h % 8 == 5) && ((h < 632 && y < 480) || (h == 797 && (y == 524 || y < 479)));
  endfunction

  function automatic logic [11:0] vaddr_f(int h, int y);
    int ly, col;
    if (h == 797) begin
      ly  = (y == 524) ? 0 : y + 1;
      col = 0;
    end else begin
      ly  = y;
      col = (h + 3) / 8;
    end
    return 12'((int'(fb_base) + ly * 80 + col) % 4096);
  endfunction

  task automatic set_pos(input int h, input int y);
    hpos = 10'(h);
    ypos = 10'(y);
    display_on = (h < 640) && (y < 480);
  endtask

  task automatic adv();
    if (hpos == 10'd799) set_pos(0, (ypos == 10'd524) ? 0 : int'(ypos) + 1);
    else                 set_pos(int'(hpos) + 1, int'(ypos));
  endtask

  task automatic cyc();
    int h, y;
    bit sl, ack_seen;
    logic [7:0] pat;
    h = int'(hpos);
    y = int'(ypos);
    pat = 8'hA5;
    sl = slot_f(h, y);
    if (track)
      pix_q.push_back(display_on ? gold[(int'(fb_base) + y * 80 + h / 8) % 4096][7 - h % 8] : 1'b0);
    @(negedge clk);
    if (track) begin
      chk("pix_out", pix_out, pix_q.pop_front());
      if (y == 0 && h < 8) chk("first_byte_pix", pix_out, pat[7 - h]);
      if (h == 797 && y == 524) chk("frame_load_addr", mem_addr, 12'h100);
      if (h == 797 && y == 0)   chk("line1_first_addr", mem_addr, 12'h150);
      if (h == 629 && y == 0)   chk("line0_last_addr", mem_addr, 12'h14F);
      if (sl) begin
        chk("video_en", mem_en, 1);
        chk("video_we", mem_we, 0);
        chk("video_addr", mem_addr, vaddr_f(h, y));
      end else if (!hammer) begin
        chk("idle_en", mem_en, 0);
      end else if (mem_en === 1'b1) begin
        chk("hammer_we", mem_we, 1);
        chk("hammer_addr", mem_addr, cpu_addr);
      end
    end
    ack_seen = (cpu_ack === 1'b1);
    if (hammer && ack_seen) begin
      hammer_acks++;
      gold[cpu_addr] = cpu_wdata;
    end
    @(posedge clk);
    #1;
    adv();
    if (hammer && ack_seen) begin
      cpu_addr  = cpu_addr + 12'd1;
      cpu_wdata = cpu_wdata + 8'd1;
    end
  endtask

  // Raise a CPU request at the current position and expect ack exactly off cycles later.
  task automatic cpu_access(input string nm, input bit we, input logic [11:0] addr,
                            input logic [7:0] wd, input int off);
    bit got, sl;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    if (we) gold[addr] = wd;
    else    exp_q.push_back(gold[addr]);
    got = 0;
    for (int c = 0; c <= off + 1 && !got; c++) begin
      sl = slot_f(int'(hpos), int'(ypos));
      @(negedge clk);
      chk({nm, "_mem_en"}, mem_en, sl || (c == off - 1));
      if (c == off - 1 && !sl) begin
        chk({nm, "_mem_we"}, mem_we, we);
        chk({nm, "_mem_addr"}, mem_addr, addr);
        if (we) chk({nm, "_mem_wdata"}, mem_wdata, wd);
      end
      chk({nm, "_ack"}, cpu_ack, c == off);
      if (cpu_ack === 1'b1) begin
        got = 1;
        if (!we && exp_q.size() > 0) chk({nm, "_rdata"}, cpu_rdata, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      adv();
    end
    if (!got && !we && exp_q.size() > 0) void'(exp_q.pop_front());
    cpu_req = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    int guard;
    vecs[0]  = '{5,   10,  1'b0, 12'h020, 8'h00, 2};
    vecs[1]  = '{2,   10,  1'b0, 12'h020, 8'h00, 1};
    vecs[2]  = '{6,   490, 1'b1, 12'h030, 8'h3C, 1};
    vecs[3]  = '{13,  10,  1'b0, 12'h030, 8'h00, 2};
    vecs[4]  = '{701, 10,  1'b0, 12'h100, 8'h00, 1};
    vecs[5]  = '{629, 10,  1'b0, 12'h021, 8'h00, 2};
    vecs[6]  = '{797, 524, 1'b0, 12'h022, 8'h00, 2};
    vecs[7]  = '{797, 479, 1'b0, 12'h023, 8'h00, 1};
    vecs[8]  = '{797, 478, 1'b0, 12'h024, 8'h00, 2};
    vecs[9]  = '{5,   480, 1'b1, 12'h025, 8'h99, 1};
    vecs[10] = '{637, 10,  1'b0, 12'h025, 8'h00, 1};
    vecs[11] = '{4,   10,  1'b0, 12'hFFF, 8'h00, 1};
    vecs[12] = '{621, 479, 1'b0, 12'h026, 8'h00, 2};
    vecs[13] = '{797, 523, 1'b0, 12'h027, 8'h00, 1};

    for (int i = 0; i < 4096; i++) begin
      vram[i] = 8'(i * 37 + 11);
      gold[i] = vram[i];
    end
    vram[12'h100] = 8'hA5;
    gold[12'h100] = 8'hA5;
    mem_rdata = 8'h00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    fb_base = 12'h100;
    set_pos(5, 0);
    reset = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_pix_out", pix_out, 0);
      @(posedge clk);
      #1;
      adv();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_pix", pix_out, 0);
    chk("post_rst_mem_en", mem_en, 0);
    @(posedge clk);
    #1;

    // Contiguous run from the frame load point through line 2, CPU writes hammering lines 1-2.
    set_pos(0, 524);
    track = 1;
    guard = 0;
    while (!(ypos == 10'd3 && hpos == 10'd0) && guard < 4000) begin
      if (ypos == 10'd1 && hpos == 10'd0) begin
        hammer = 1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'hF00; cpu_wdata = 8'h00;
      end
      cyc();
      guard++;
    end
    chk("track_run_done", guard < 4000, 1);
    track = 0; hammer = 0; cpu_req = 1'b0;
    repeat (3) cyc();
`ifdef VRAM_ARB_BLANK_WRITE_EN
    chk("hammer_acks_visible", hammer_acks, 0);
`else
    chk("hammer_acks_min", hammer_acks >= 600, 1);
`endif

    for (int i = 0; i < 14; i++) begin
      set_pos(vecs[i].h, vecs[i].y);
      cpu_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].ack_off);
    end

    // Write inside the visible area.
    set_pos(100, 100);
`ifdef VRAM_ARB_BLANK_WRITE_EN
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h050; cpu_wdata = 8'h77;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("blank_hold_ack", cpu_ack, 0);
      @(posedge clk);
      #1;
      adv();
    end
    set_pos(int'(hpos), 480);
`endif
    cpu_access("visible_write", 1'b1, 12'h050, 8'h77, 1);
    set_pos(20, 490);
    cpu_access("readback_050", 1'b0, 12'h050, 8'h00, 1);
    set_pos(100, 100);
    cpu_access("visible_read", 1'b0, 12'h051, 8'h00, 1);

    // Reset during the DATA cycle: no ack may escape.
    set_pos(2, 10);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
    @(negedge clk);
    chk("abort_issue_en", mem_en, 1);
    @(posedge clk);
    #1;
    adv();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ack_in_reset", cpu_ack, 0);
    @(posedge clk);
    #1;
    adv();
    reset = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_ack_after", cpu_ack, 0);
    chk("abort_mem_en_after", mem_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
